// File: rtl/pingpong_bram.sv
// rtl/pingpong_bram.sv - two-bank ping-pong block RAM with drained bank swap
module pingpong_bram #(
    parameter int DW     = 12,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] din,
    input  logic          ren,
    input  logic [AW-1:0] raddr,
    output logic          ren_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          wr_bank,
    output logic [AW:0]   wcnt,
    output logic          wfull
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic {RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic                swap_ack_q, swap_ack_d;
    logic [AW:0]         wcnt_q, wcnt_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [DW-1:0]       rd_data_q, rd_data_d;
    logic                accept;
    logic                in_flight;
    logic                toggle;

    // Both banks share one array; the bank index is the top address bit.
    logic [DW-1:0] mem [2*DEPTH];

    assign accept    = ren && (state_q == RUN);
    assign in_flight = |vld_q;

    always_comb begin
        state_d = state_q;
        toggle  = 1'b0;
        case (state_q)
            RUN: begin
                // A swap on the ack cycle is ignored so one request yields one toggle.
                if (swap_req && !swap_ack_q) begin
                    if (!in_flight && !ren) toggle = 1'b1;
                    else                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight) begin
                    toggle  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wr_bank_d  = wr_bank_q ^ toggle;
        swap_ack_d = toggle;
        wcnt_d     = wcnt_q;
        if (toggle)
            wcnt_d = {{AW{1'b0}}, wen};
        else if (wen && (wcnt_q != FULL))
            wcnt_d = wcnt_q + 1'b1;
        rd_data_d = accept ? mem[{~wr_bank_q, raddr}] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (wen) mem[{wr_bank_q, waddr}] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wr_bank_q  <= 1'b0;
            swap_ack_q <= 1'b0;
            wcnt_q     <= '0;
            vld_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            swap_ack_q <= swap_ack_d;
            wcnt_q     <= wcnt_d;
            vld_q      <= vld_d;
            rd_data_q  <= rd_data_d;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign vld_d      = accept;
            assign dout       = rd_data_q;
            assign dout_valid = vld_q[0];
        end else if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] dout_q, dout_d;
            assign vld_d = {vld_q[0], accept};
            always_comb dout_d = vld_q[0] ? rd_data_q : dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else        dout_q <= dout_d;
            end
            assign dout       = dout_q;
            assign dout_valid = vld_q[1];
        end else begin : g_bad_lat
            $error("pingpong_bram: RD_LAT must be 1 or 2");
        end
    endgenerate

    assign ren_ready = (state_q == RUN);
    assign swap_ack  = swap_ack_q;
    assign wr_bank   = wr_bank_q;
    assign wcnt      = wcnt_q;
    assign wfull     = (wcnt_q == FULL);
endmodule

// File: tb/tb_pingpong_bram.sv
// tb/tb_pingpong_bram.sv - directed bench for pingpong_bram at RD_LAT 1 and 2
module tb_pingpong_bram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wen = 1'b0;
    logic [7:0]  waddr = '0;
    logic [11:0] din = '0;
    logic        ren = 1'b0;
    logic [7:0]  raddr = '0;
    logic        swap_req = 1'b0;

    logic        rr1, dv1, sa1, wb1, wf1;
    logic [11:0] do1;
    logic [8:0]  wc1;
    logic        rr2, dv2, sa2, wb2, wf2;
    logic [11:0] do2;
    logic [8:0]  wc2;

    int total = 0;
    int bad   = 0;

    pingpong_bram #(.DW(12), .AW(8), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .din(din),
        .ren(ren), .raddr(raddr), .ren_ready(rr1), .dout(do1), .dout_valid(dv1),
        .swap_req(swap_req), .swap_ack(sa1), .wr_bank(wb1), .wcnt(wc1), .wfull(wf1)
    );

    pingpong_bram #(.DW(12), .AW(8), .RD_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .din(din),
        .ren(ren), .raddr(raddr), .ren_ready(rr2), .dout(do2), .dout_valid(dv2),
        .swap_req(swap_req), .swap_ack(sa2), .wr_bank(wb2), .wcnt(wc2), .wfull(wf2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dout1", do1, 0);   chk("rst_dv1", dv1, 0);
        chk("rst_ack1", sa1, 0);    chk("rst_wb1", wb1, 0);
        chk("rst_wcnt1", wc1, 0);   chk("rst_rr1", rr1, 1);
        chk("rst_dout2", do2, 0);   chk("rst_dv2", dv2, 0);
        tick();
        rst_n = 1'b1;

        // 300 writes into bank 0 with data = addr + 5
        for (int i = 0; i < 300; i++) begin
            wen = 1'b1; waddr = 8'(i); din = 12'((i % 256) + 5);
            tick();
            if (i == 254) begin chk("wcnt255", wc1, 255); chk("wfull255", wf1, 0); end
            if (i == 255) begin chk("wcnt256", wc1, 256); chk("wfull256", wf1, 1); end
        end
        wen = 1'b0;
        chk("sat_wcnt1", wc1, 256); chk("sat_wfull1", wf1, 1);
        chk("sat_wcnt2", wc2, 256); chk("sat_wfull2", wf2, 1);

        // idle swap with a write on the toggling edge; request held into ack cycle
        swap_req = 1'b1; wen = 1'b1; waddr = 8'd0; din = 12'd5;
        tick();
        wen = 1'b0;
        chk("sw_wb1", wb1, 1);   chk("sw_ack1", sa1, 1);
        chk("sw_wcnt1", wc1, 1); chk("sw_wfull1", wf1, 0);
        chk("sw_wb2", wb2, 1);   chk("sw_ack2", sa2, 1);
        tick();
        swap_req = 1'b0;
        chk("ign_ack1", sa1, 0); chk("ign_wb1", wb1, 1);
        chk("ign_ack2", sa2, 0); chk("ign_wb2", wb2, 1);
        tick();
        chk("ign_wb1_b", wb1, 1); chk("ign_rr1", rr1, 1);

        // reads from bank 0: raddr 7, then back-to-back 0,1,2
        ren = 1'b1; raddr = 8'd7;
        tick();
        chk("r7_dout1", do1, 12); chk("r7_dv1", dv1, 1); chk("r7_dv2", dv2, 0);
        raddr = 8'd0;
        tick();
        chk("r0_dout1", do1, 5);  chk("r7_dout2", do2, 12); chk("r7_dv2b", dv2, 1);
        raddr = 8'd1;
        tick();
        chk("r1_dout1", do1, 6);  chk("r0_dout2", do2, 5);
        raddr = 8'd2;
        tick();
        chk("r2_dout1", do1, 7);  chk("r1_dout2", do2, 6);
        ren = 1'b0;
        tick();
        chk("idle_dv1", dv1, 0);  chk("hold_dout1", do1, 7);
        chk("r2_dout2", do2, 7);  chk("r2_dv2", dv2, 1);
        tick();
        chk("idle_dv2", dv2, 0);  chk("hold_dout2", do2, 7);

        // drain: read and swap request in the same cycle N
        ren = 1'b1; raddr = 8'd9; swap_req = 1'b1;
        tick();
        ren = 1'b0; swap_req = 1'b0;
        chk("dr1_rr1", rr1, 0);  chk("dr1_dv1", dv1, 1); chk("dr1_dout1", do1, 14);
        chk("dr1_wb1", wb1, 1);  chk("dr1_rr2", rr2, 0); chk("dr1_dv2", dv2, 0);
        tick();
        chk("dr2_wb1", wb1, 1);  chk("dr2_rr1", rr1, 0); chk("dr2_dv1", dv1, 0);
        chk("dr2_dv2", dv2, 1);  chk("dr2_dout2", do2, 14);
        tick();
        chk("dr3_wb1", wb1, 0);  chk("dr3_ack1", sa1, 1); chk("dr3_rr1", rr1, 1);
        chk("dr3_wcnt1", wc1, 0);
        chk("dr3_wb2", wb2, 1);  chk("dr3_ack2", sa2, 0); chk("dr3_rr2", rr2, 0);
        tick();
        chk("dr4_ack1", sa1, 0); chk("dr4_wb1", wb1, 0);
        chk("dr4_wb2", wb2, 0);  chk("dr4_ack2", sa2, 1); chk("dr4_rr2", rr2, 1);
        tick();

        // back to bank 1 and put a marker at address 3
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("s2_wb1", wb1, 1); chk("s2_wb2", wb2, 1);
        wen = 1'b1; waddr = 8'd3; din = 12'hABC;
        tick();
        wen = 1'b0;
        chk("mk_wcnt1", wc1, 1);
        tick();

        // reset in DRAIN with a read in flight
        ren = 1'b1; raddr = 8'd7; swap_req = 1'b1;
        tick();
        ren = 1'b0; swap_req = 1'b0;
        chk("pr_rr1", rr1, 0); chk("pr_dv1", dv1, 1); chk("pr_dout1", do1, 12);
        rst_n = 1'b0;
        #1;
        chk("ar_dv1", dv1, 0);  chk("ar_dout1", do1, 0); chk("ar_wb1", wb1, 0);
        chk("ar_wcnt1", wc1, 0); chk("ar_ack1", sa1, 0); chk("ar_rr1", rr1, 1);
        chk("ar_dv2", dv2, 0);  chk("ar_wb2", wb2, 0);  chk("ar_wcnt2", wc2, 0);
        tick();
        tick();
        chk("ar_ack1b", sa1, 0); chk("ar_ack2b", sa2, 0);
        rst_n = 1'b1;
        ren = 1'b1; raddr = 8'd3;
        tick();
        ren = 1'b0;
        chk("post_dout1", do1, 12'hABC); chk("post_dv1", dv1, 1);
        chk("post_dv2a", dv2, 0);        chk("post_wb1", wb1, 0);
        tick();
        chk("post_dout2", do2, 12'hABC); chk("post_dv2", dv2, 1);
        chk("post_ack1", sa1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pingpong_bram.md
PINGPONG_BRAM -- requirements
Module: pingpong_bram

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- DW, 12, data word width in bits
- AW, 8, address width; each bank holds 2^AW words
- RD_LAT, 1, read latency in cycles; legal values 1 or 2; any other value is an elaboration error
REQ-002 The block SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all logic samples on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wen  input  1  write enable into the current write bank
- waddr  input  AW  write address
- din  input  DW  write data
- ren  input  1  read request from the current read bank
- raddr  input  AW  read address
- ren_ready  output  1  read request is accepted this cycle
- dout  output  DW  read data
- dout_valid  output  1  dout holds data for an accepted request
- swap_req  input  1  single-cycle request to exchange the banks
- swap_ack  output  1  single-cycle pulse on the cycle after the swap takes effect
- wr_bank  output  1  index of the bank being written
- wcnt  output  AW+1  number of writes to wr_bank since the last swap or reset
- wfull  output  1  wcnt equals 2^AW

Function
REQ-003 Storage SHALL be two banks of 2^AW x DW, inferred as block RAM, and SHALL have no reset on contents.
REQ-004 Writes SHALL go to bank wr_bank; reads SHALL come from bank ~wr_bank. The bank is sampled before the active clock edge.
REQ-005 A read SHALL be accepted when ren=1 and ren_ready=1. Requests with ren_ready=0 SHALL be dropped silently.
REQ-006 Accepted read data SHALL appear on dout with dout_valid=1 exactly RD_LAT cycles after the accepting edge. The pipeline SHALL be fully pipelined with one accept per cycle.
REQ-007 When no read is in flight, dout SHALL hold its last value and dout_valid SHALL be 0.
REQ-008 The FSM SHALL have two states, RUN and DRAIN. ren_ready SHALL equal 1 only in RUN.
REQ-009 A swap_req in RUN, with no read in flight and ren=0, SHALL toggle wr_bank at that edge and assert swap_ack the following cycle; the FSM SHALL stay in RUN.
REQ-010 A swap_req in RUN with a read in flight, or with ren=1 accepted in the same cycle, SHALL move the FSM to DRAIN. The FSM SHALL toggle wr_bank on the first edge at which the read pipeline is empty, pulse swap_ack for 1 cycle, and return to RUN.
REQ-011 swap_req in DRAIN, or on the swap_ack cycle, SHALL be ignored.
REQ-012 Writes SHALL be accepted in every state. A write at the toggling edge SHALL go to the old wr_bank.
REQ-013 wcnt SHALL increment by 1 on each wen=1 and saturate at 2^AW. On the toggling edge, wcnt SHALL load 0, or 1 if wen=1 at that edge.
REQ-014 wfull SHALL be combinational from wcnt. Writes while wfull=1 SHALL still update memory (overwrite is allowed); wcnt stays saturated.
REQ-015 Address arithmetic SHALL be plain AW-bit indexing with no wrap logic; raddr and waddr are used as given.

Reset
REQ-016 While rst_n=0, the following SHALL hold asynchronously: wr_bank=0, FSM=RUN, ren_ready=1 after release, dout=0, dout_valid=0, swap_ack=0, wcnt=0, and all in-flight reads discarded.
REQ-017 Reset asserted mid-DRAIN SHALL abort the swap: no swap_ack, and wr_bank=0.
REQ-018 The first rising edge after rst_n rises SHALL be a normal operating edge.

Verification
REQ-019 Basic ping-pong, RD_LAT=1: write 0..255 with data=addr+5 to bank 0, then swap_req with the pipeline idle -> swap_ack 1 cycle later, wr_bank=1; then ren raddr=7 -> dout=12 with dout_valid 1 cycle after the accept.
REQ-020 Latency 2: with RD_LAT=2, repeat REQ-019 with back-to-back reads of raddr 0,1,2 -> dout 5,6,7 on consecutive cycles starting 2 cycles after the first accept.
REQ-021 Drain: ren on cycle N with swap_req on cycle N -> ren_ready=0 from N+1, dout_valid at N+RD_LAT, wr_bank toggles once the pipeline is empty, swap_ack 1 cycle after the toggle, ren_ready=1 again.
REQ-022 Saturation: 300 consecutive writes -> wcnt=256 and wfull=1; a swap with wen=1 on the toggling edge -> wcnt=1 and wfull=0.
REQ-023 Reset mid-operation: rst_n low during DRAIN with 1 read in flight -> dout_valid=0 immediately, no swap_ack, wr_bank=0, wcnt=0; the first read after release returns the pre-reset contents of bank 1.
REQ-024 Ignored request: swap_req on the swap_ack cycle -> no second toggle, and wr_bank changes only once.
